// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings, LSU state type and lane-offset helper.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } lsu_state_t;

    // Byte lane used by an access: bytes honour both low bits, halfwords only
    // addr[1], words always lane 0 (low bits are ignored when not trapping).
    function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] a);
        logic [1:0] off;
        off = 2'b00;
        if (f3 == F3_B || f3 == F3_BU) begin
            off = a;
        end else if (f3 == F3_H || f3 == F3_HU) begin
            off = {a[1], 1'b0};
        end
        return off;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data path: selects the addressed lane of the read word and sign/zero extends it.
module lsu_load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {lane_offset(funct3_i, addr_lo_i), 3'b000};
        case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data_o = {24'h000000, shifted[7:0]};
            F3_HU:   data_o = {16'h0000, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: valid/ready issue, req/ack memory port, one-cycle writeback pulse.
// Define MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of ignoring low bits.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int Data_Width   = 32,
    parameter int AddrRegWidth = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    is_load,
    input  logic                    is_store,
    input  logic [2:0]              funct3,
    input  logic [Data_Width-1:0]   op_a,
    input  logic [Data_Width-1:0]   op_b,
    input  logic [Data_Width-1:0]   imm,
    input  logic [AddrRegWidth-1:0] rd_in,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [Data_Width-1:0]   mem_addr,
    output logic [Data_Width-1:0]   mem_wdata,
    output logic [3:0]              mem_wstrb,
    input  logic                    mem_ack,
    input  logic [Data_Width-1:0]   mem_rdata,
    output logic                    wb_en,
    output logic [AddrRegWidth-1:0] wb_rd,
    output logic [Data_Width-1:0]   wb_data,
    output logic                    fault
);

    lsu_state_t              state_q, state_d;
    logic                    mem_req_q, mem_we_q;
    logic [31:0]             mem_addr_q, mem_wdata_q;
    logic [3:0]              mem_wstrb_q;
    logic [2:0]              funct3_q;
    logic [1:0]              addr_lo_q;
    logic [AddrRegWidth-1:0] rd_q, wb_rd_q;
    logic                    load_q, wb_en_q, fault_q;
    logic [31:0]             wb_data_q;

    logic        accept, illegal, go, misalign, load_f3_ok, store_f3_ok, do_wb;
    logic [31:0] eff_addr, st_wdata, ld_data;
    logic [3:0]  st_wstrb;
    logic [1:0]  off;

    always_comb begin
        eff_addr    = op_a + imm;
        accept      = req_valid && (state_q == IDLE);
        load_f3_ok  = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                      (funct3 == F3_BU) || (funct3 == F3_HU);
        store_f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
`ifdef MISALIGN_TRAP_EN
        misalign    = (((funct3 == F3_H) || (funct3 == F3_HU)) && eff_addr[0]) ||
                      ((funct3 == F3_W) && (eff_addr[1:0] != 2'b00));
`else
        misalign    = 1'b0;
`endif
        illegal     = (is_load && is_store) ||
                      (is_load && !load_f3_ok) ||
                      (is_store && !store_f3_ok) ||
                      ((is_load || is_store) && misalign);
        go          = accept && (is_load ^ is_store) && !illegal;
        off         = lane_offset(funct3, eff_addr[1:0]);
        case (funct3)
            F3_B: begin
                st_wdata = {4{op_b[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            F3_H: begin
                st_wdata = {2{op_b[15:0]}};
                st_wstrb = 4'b0011 << off;
            end
            default: begin
                st_wdata = op_b;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    lsu_load_align u_align (
        .rdata_i   (mem_rdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .data_o    (ld_data)
    );

    // Loads to x0 complete the access but skip the writeback state entirely.
    assign do_wb = load_q && (rd_q != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = REQ;
            REQ:     if (mem_ack) state_d = do_wb ? WB : IDLE;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            rd_q        <= '0;
            load_q      <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= accept && illegal;
            wb_en_q <= 1'b0;
            if (state_q == IDLE && go) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= is_store;
                mem_addr_q  <= {eff_addr[31:2], 2'b00};
                mem_wdata_q <= is_store ? st_wdata : '0;
                mem_wstrb_q <= is_store ? st_wstrb : '0;
                funct3_q    <= funct3;
                addr_lo_q   <= eff_addr[1:0];
                rd_q        <= rd_in;
                load_q      <= is_load;
            end
            if (state_q == REQ && mem_ack) begin
                mem_req_q <= 1'b0;
                if (do_wb) begin
                    wb_en_q   <= 1'b1;
                    wb_rd_q   <= rd_q;
                    wb_data_q <= ld_data;
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-addressed memory models, random and directed ops.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, imm;
    logic [4:0]  rd_in;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_en, fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    load_store_unit #(.Data_Width(32), .AddrRegWidth(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .op_a(op_a),
        .op_b(op_b), .imm(imm), .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int unsigned start;
    } mem_exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    mem_exp_t    exp_mem[$];
    wb_exp_t     exp_wb[$];
    int unsigned exp_fault[$];

    int unsigned cyc = 0;
    int          compared = 0, mismatched = 0;
    logic [7:0]  mm [logic [31:0]];   // reference model memory
    logic [7:0]  dm [logic [31:0]];   // memory seen by the DUT
    int          fixed_delay = 0;
    bit          hold_mode = 0, poke_ack = 0;
    int          last_hold = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return h[31:24];
    endfunction

    function automatic logic [31:0] mm_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = mm.exists(a + i) ? mm[a + i] : init_byte(a + i);
        return w;
    endfunction

    function automatic logic [31:0] dm_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = dm.exists(a + i) ? dm[a + i] : init_byte(a + i);
        return w;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mm[a + i] = w[8*i +: 8];
            dm[a + i] = w[8*i +: 8];
        end
    endtask

    // Memory responder: acks after a random (or fixed) number of mem_req cycles.
    initial begin
        int cnt, target;
        cnt = 0;
        target = 1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (poke_ack) begin
                poke_ack = 0;
                mem_ack = 1'b1;
                mem_rdata = $urandom;
            end else if (mem_req && !hold_mode) begin
                if (cnt == 0) target = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 4);
                cnt++;
                if (cnt == target) begin
                    mem_ack = 1'b1;
                    mem_rdata = $urandom;
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_wstrb[i]) dm[mem_addr + i] = mem_wdata[8*i +: 8];
                    end else begin
                        mem_rdata = dm_word(mem_addr);
                    end
                    cnt = 0;
                end
            end else if (!mem_req) begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes an access, writes back or faults.
    bit          in_xfer = 0;
    int          hold = 0;
    int unsigned f_cyc = 0, ack_cyc = 0;
    logic [31:0] f_addr, f_wdata;
    logic [3:0]  f_wstrb;
    logic        f_we;

    always @(negedge clk) begin
        if (rst) begin
            in_xfer = 0;
        end else begin
            if (mem_req) begin
                if (!in_xfer) begin
                    in_xfer = 1;
                    hold = 0;
                    f_addr = mem_addr; f_wdata = mem_wdata; f_wstrb = mem_wstrb; f_we = mem_we;
                    f_cyc = cyc;
                end else begin
                    chk("mem_addr_stable", mem_addr, f_addr);
                    chk("mem_wdata_stable", mem_wdata, f_wdata);
                    chk("mem_wstrb_stable", {28'h0, mem_wstrb}, {28'h0, f_wstrb});
                    chk("mem_we_stable", {31'h0, mem_we}, {31'h0, f_we});
                end
                hold++;
                if (mem_ack) begin
                    if (exp_mem.size() == 0) begin
                        chk("unexpected_mem_access", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        mem_exp_t e;
                        e = exp_mem.pop_front();
                        chk("mem_addr", mem_addr, e.addr);
                        chk("mem_we", {31'h0, mem_we}, {31'h0, e.we});
                        chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
                        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                        chk("mem_req_start_cycle", f_cyc, e.start);
                    end
                    last_hold = hold;
                    ack_cyc = cyc;
                    in_xfer = 0;
                end
            end
            if (wb_en) begin
                if (exp_wb.size() == 0) begin
                    chk("unexpected_wb_en", {27'h0, wb_rd}, 32'hFFFF_FFFF);
                end else begin
                    wb_exp_t w;
                    w = exp_wb.pop_front();
                    chk("wb_rd", {27'h0, wb_rd}, {27'h0, w.rd});
                    chk("wb_data", wb_data, w.data);
                    chk("wb_cycle_after_ack", cyc, ack_cyc + 1);
                end
            end
            if (fault) begin
                if (exp_fault.size() == 0) begin
                    chk("unexpected_fault", 32'h1, 32'h0);
                end else begin
                    chk("fault_cycle", cyc, exp_fault.pop_front());
                    chk("fault_no_mem_req", {31'h0, mem_req}, 32'h0);
                end
            end
        end
    end

    // Issue one request; the expected outcome comes from the ISA-level model below.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] rd);
        int          n;
        logic [31:0] eff, word, field, data, wdata;
        logic [3:0]  strb;
        int          off;
        bit          bad, mis;
        int unsigned acc;
        mem_exp_t    me;
        wb_exp_t     we;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (req_ready) break;
            // requests offered while busy must be ignored
            req_valid = 1'b1; is_load = $urandom_range(0, 1); is_store = $urandom_range(0, 1);
            funct3 = $urandom_range(0, 7); op_a = $urandom; op_b = $urandom; imm = $urandom;
            rd_in = $urandom_range(0, 31);
            n++;
            if (n > 200) begin
                chk("req_ready_timeout", 32'h0, 32'h1);
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        op_a = a; op_b = b; imm = im; rd_in = rd;

        eff = a + im;
        mis = 0;
`ifdef MISALIGN_TRAP_EN
        mis = ((f3 == 3'd1 || f3 == 3'd5) && eff[0]) || (f3 == 3'd2 && eff[1:0] != 2'd0);
`endif
        bad = (ld && st) || (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
              (st && !(f3 inside {3'd0, 3'd1, 3'd2})) || ((ld || st) && mis);
        if (f3 == 3'd0 || f3 == 3'd4) off = int'(eff[1:0]);
        else if (f3 == 3'd1 || f3 == 3'd5) off = eff[1] ? 2 : 0;
        else off = 0;

        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc = cyc;
        if (bad) begin
            exp_fault.push_back(acc);
        end else if (st) begin
            if (f3 == 3'd0) begin strb = 4'b0001 << off; wdata = {4{b[7:0]}}; end
            else if (f3 == 3'd1) begin strb = 4'b0011 << off; wdata = {2{b[15:0]}}; end
            else begin strb = 4'b1111; wdata = b; end
            me = '{addr: {eff[31:2], 2'b00}, we: 1'b1, wdata: wdata, wstrb: strb, start: acc};
            exp_mem.push_back(me);
            for (int i = 0; i < 4; i++)
                if (strb[i]) mm[{eff[31:2], 2'b00} + i] = wdata[8*i +: 8];
        end else if (ld) begin
            me = '{addr: {eff[31:2], 2'b00}, we: 1'b0, wdata: 32'h0, wstrb: 4'h0, start: acc};
            exp_mem.push_back(me);
            word = mm_word({eff[31:2], 2'b00});
            field = word >> (8 * off);
            case (f3)
                3'd0:    data = {{24{field[7]}}, field[7:0]};
                3'd1:    data = {{16{field[15]}}, field[15:0]};
                3'd4:    data = field & 32'h0000_00FF;
                3'd5:    data = field & 32'h0000_FFFF;
                default: data = word;
            endcase
            if (rd != 5'd0) begin
                we = '{rd: rd, data: data};
                exp_wb.push_back(we);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_mem.size() != 0 || exp_wb.size() != 0 || exp_fault.size() != 0 || !req_ready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 500) begin
                chk("drain_timeout", exp_mem.size() + exp_wb.size() + exp_fault.size(), 0);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ld, st;
        logic [2:0] f3;
        int r;
        rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
        op_a = '0; op_b = '0; imm = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_wb_en", {31'h0, wb_en}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        rst = 1'b0;

        issue(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'd4, 5'd7);
        set_word(32'h100, 32'h80112233);
        issue(1, 0, 3'd0, 32'h100, 32'h0, 32'd3, 5'd9);
        issue(1, 0, 3'd4, 32'h100, 32'h0, 32'd3, 5'd10);
        issue(0, 1, 3'd1, 32'h100, 32'h0000ABCD, 32'd2, 5'd1);
        issue(0, 1, 3'd1, 32'hFFFFFFFC, 32'h00001234, 32'd8, 5'd1);
        drain();
        fixed_delay = 3;
        issue(1, 0, 3'd2, 32'h100, 32'h0, 32'd0, 5'd0);
        drain();
        chk("lw_x0_mem_req_hold", last_hold, 3);
        fixed_delay = 0;
        issue(1, 0, 3'd2, 32'h100, 32'h0, 32'd2, 5'd3);
        issue(1, 1, 3'd2, 32'h100, 32'h0, 32'd0, 5'd4);
        issue(0, 1, 3'd4, 32'h100, 32'h0, 32'd0, 5'd4);
        issue(0, 0, 3'd2, 32'h100, 32'h0, 32'd0, 5'd4);
        drain();

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            ld = (r <= 3) || r == 7 || (r == 9 && $urandom_range(0, 1) == 1);
            st = (r >= 4 && r <= 7) || (r == 9 && !ld);
            if (r <= 3) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end else if (r <= 6) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            issue(ld, st, f3, 32'h1000 + $urandom_range(0, 63),
                  $urandom, 32'($urandom_range(0, 31)) - 32'd16, 5'($urandom_range(0, 31)));
        end
        drain();

        // Reset in the middle of an access: no ack, no writeback, late ack ignored.
        hold_mode = 1;
        issue(1, 0, 3'd2, 32'h200, 32'h0, 32'd0, 5'd5);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_req_busy", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("async_rst_req_ready", {31'h0, req_ready}, 32'h1);
        exp_mem.delete();
        exp_wb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold_mode = 0;
        poke_ack = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("late_ack_mem_req", {31'h0, mem_req}, 32'h0);
        chk("late_ack_req_ready", {31'h0, req_ready}, 32'h1);
        issue(1, 0, 3'd5, 32'h100, 32'h0, 32'd1, 5'd12);
        issue(0, 1, 3'd0, 32'h103, 32'h000000A5, 32'd0, 5'd0);
        issue(1, 0, 3'd2, 32'h100, 32'h0, 32'd0, 5'd13);
        drain();
        chk("final_queues_empty", exp_mem.size() + exp_wb.size() + exp_fault.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
